// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Returns {remainder, quotient}; ready holds until start drops.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  state_t state, state_nx;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dvd;
  logic [DATA_W-1:0]   dsr;
  logic                neg_q;
  logic                neg_r;

  logic [DATA_W-1:0]   abs1;
  logic [DATA_W-1:0]   abs2;
  logic [DATA_W:0]     shl_rem;
  logic [DATA_W:0]     diff;
  logic                borrow;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   dvd_nx;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                unused_ok;

  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;
  logic                go;
  logic                done;

  assign go   = start_i && !annul_i;
  assign done = (cnt == LAST);

  // Magnitudes fed to the unsigned core.
  assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // One restoring step: the shifted remainder needs DATA_W+1 bits,
  // and the borrow out of the trial subtract is the inverted quotient bit.
  assign shl_rem          = {rem, dvd[DATA_W-1]};
  assign {borrow, diff}   = {1'b0, shl_rem} - {2'b00, dsr};
  assign rem_nx           = borrow ? shl_rem[DATA_W-1:0] : diff[DATA_W-1:0];
  assign dvd_nx           = {dvd[DATA_W-2:0], ~borrow};
  assign unused_ok        = diff[DATA_W];

  assign quo_fix = neg_q ? -dvd : dvd;
  assign rem_fix = neg_r ? -rem : rem;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst_n) state <= FREE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      FREE: begin
        if (go) state_nx = (opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: state_nx = END;
      ON: begin
        if (annul_i)   state_nx = FREE;
        else if (done) state_nx = END;
      end
      END: begin
        if (!start_i) state_nx = FREE;
      end
      default: state_nx = FREE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    result_d = result_o;
    ready_d  = ready_o;
    unique case (state)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else if (done) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // Operand latch, iteration datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      result_o <= result_d;
      ready_o  <= ready_d;
      if (state == FREE && go) begin
        cnt   <= '0;
        rem   <= '0;
        dvd   <= abs1;
        dsr   <= abs2;
        neg_q <= signed_div_i &&
                 (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        neg_r <= signed_div_i && opdata1_i[DATA_W-1];
      end else if (state == ON && !annul_i && !done) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases, random operands vs. an
// arithmetic reference, annul, reset and handshake boundaries.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int pass_cnt;
  int total_cnt;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .Clk          (clk),
    .Rst_n        (rst),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, C-style truncation toward zero.
  function automatic logic [63:0] model(input logic s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one division, hold start until ready, then release.
  task automatic run_div(input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble,
                         input string tag);
    logic [63:0] exp;
    int exp_lat;
    int n;
    exp     = model(s, a, b);
    exp_lat = (b == 32'd0) ? 2 : 34;
    sgn   = s;
    op1   = a;
    op2   = b;
    start = 1'b1;
    annul = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ready) break;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        sgn = 1'($urandom);
      end
    end
    total_cnt++;
    if (n !== exp_lat)
      $display("FAIL %s latency: got %0d want %0d", tag, n, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (result !== exp)
      $display("FAIL %s result: got %h want %h", tag, result, exp);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL %s release: got ready=%b res=%h want 0/0",
               tag, ready, result);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    sgn = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL reset: got ready=%b res=%h want 0/0", ready, result);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
    total_cnt++;
    if (model(1'b0, 32'd100, 32'd7) !== 64'h00000002_0000000E)
      $display("FAIL model_100_7: got %h want %h",
               model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    else pass_cnt++;
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0, "div_m7_2");
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0, "div_7_m2");
    run_div(1'b1, 32'd5, 32'd0, 1'b0, "div_by_zero");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
    run_div(1'b1, 32'h80000000, 32'h80000000, 1'b0, "div_min_min");
    run_div(1'b0, 32'd3, 32'hFFFFFFFF, 1'b0, "divu_small_big");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      if (i % 4 == 1) b = b >> $urandom_range(31, 16);
      if (i == 6) b = 32'd0;
      run_div(s, a, b, 1'b0, "random");
    end
  endtask

  task automatic test_input_change;
    run_div(1'b1, 32'hDEADBEEF, 32'h00001234, 1'b1, "scramble_div");
    run_div(1'b0, 32'hCAFEF00D, 32'h00000013, 1'b1, "scramble_divu");
    run_div(1'b0, 32'd77, 32'd0, 1'b1, "scramble_zero");
  endtask

  task automatic test_end_hold;
    logic [63:0] exp;
    int n;
    exp = model(1'b1, 32'hFFFFF000, 32'd10);
    sgn = 1'b1;
    op1 = 32'hFFFFF000;
    op2 = 32'd10;
    start = 1'b1;
    n = 0;
    while (n < 40 && ready !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    annul = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b1 || result !== exp)
      $display("FAIL end_hold: got ready=%b res=%h want 1/%h",
               ready, result, exp);
    else pass_cnt++;
    annul = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0)
      $display("FAIL end_release: got ready=%b want 0", ready);
    else pass_cnt++;
  endtask

  task automatic test_annul;
    bit seen;
    seen = 1'b0;
    sgn = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    annul = 1'b0;
    repeat (11) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    if (ready) seen = 1'b1;
    annul = 1'b0;
    total_cnt++;
    if (seen)
      $display("FAIL annul_ready: got ready=1 want 0");
    else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, 1'b0, "after_annul");
    start = 1'b1;
    annul = 1'b1;
    sgn = 1'b0;
    op1 = 32'd50;
    op2 = 32'd5;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    start = 1'b0;
    annul = 1'b0;
    total_cnt++;
    if (seen)
      $display("FAIL annul_in_free: got ready=1 want 0");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    sgn = 1'b0;
    op1 = 32'd12345;
    op2 = 32'd17;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0 || result !== 64'd0)
      $display("FAIL reset_mid: got ready=%b res=%h want 0/0",
               ready, result);
    else pass_cnt++;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    run_div(1'b0, 32'd100, 32'd7, 1'b0, "after_reset");
    rst = 1'b1;
    start = 1'b1;
    op1 = 32'd8;
    op2 = 32'd2;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    total_cnt++;
    if (seen)
      $display("FAIL reset_vs_start: got ready=1 want 0");
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset;
    test_directed;
    test_random;
    test_input_change;
    test_end_hold;
    test_annul;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32/32 integer divider for DIV and DIVU.
- Sits beside the execute stage, which is directly downstream of instruction decode: decode issues EXE_DIV_OP or EXE_DIVU_OP, and execute forwards the operands here.
- Execute stalls the pipeline until ready_o, then writes result_o to HI/LO: remainder to HI, quotient to LO.
- Restoring algorithm, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst_n  input  1  synchronous, active-high reset (Rst_n==1 resets on the rising edge of Clk, i.e. RstEnable).
- signed_div_i  input  1  1=DIV (two's complement), 0=DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; held high by execute until ready_o is seen.
- annul_i  input  1  abort the current division (flush).
- result_o  output  2*DATA_W  {remainder, quotient}.
- ready_o  output  1  result valid.

Behaviour:
- Registered outputs; reset values: result_o=0, ready_o=0, state=FREE, counter=0.
- States and transitions:
  - FREE: if start_i && !annul_i, latch operands and signed_div_i.
    - Divisor==0 -> BYZERO.
    - Otherwise -> ON with cnt=0.
    - In signed mode, a negative operand is replaced by its two's complement before latching.
  - BYZERO: -> END with result 0.
  - ON:
    - If annul_i: -> FREE, ready_o stays 0, partial result discarded.
    - Else if cnt<DATA_W: one restoring step per cycle. Shift the {partial remainder, dividend} register left by 1, trial-subtract the divisor, keep the difference if non-negative, and shift in the quotient bit (1 if kept, else 0). Then cnt++.
    - When cnt==DATA_W: apply sign correction, load result_o, -> END.
  - END: ready_o=1 and result_o held stable. When start_i==0: -> FREE, ready_o=0, result_o cleared to 0.
- Sign correction (signed mode only):
  - Quotient negated iff sign(opdata1) != sign(opdata2).
  - Remainder negated iff opdata1 is negative.
  - Remainder sign always follows the dividend.
- Latency, with start sampled at edge E0:
  - Normal: ON iterates on E1..E32, END entered at E33; ready_o visible after E33.
  - Divide-by-zero: ready_o visible after E1.
- Boundaries:
  - start_i changes during ON or BYZERO: ignored; the operands were latched in FREE.
  - annul_i in FREE suppresses start; annul_i in END is ignored (result already delivered).
  - 0x80000000 / 0xFFFFFFFF in signed mode: quotient wraps to 0x80000000, remainder 0. No trap.
  - Rst_n mid-operation: next edge -> FREE with all outputs at reset values; no residual ready.
  - Simultaneous start_i and Rst_n: reset wins.
- Arithmetic: the trial subtraction is DATA_W+1 bits wide; its carry/borrow selects the quotient bit.

Test Plan:
- DIVU 100/7, start held: ready_o rises after E33 with result_o=64'h00000002_0000000E; deassert start -> ready_o=0 next cycle and result_o=0.
- DIV -7/2 (0xFFFFFFF9, 0x00000002): result_o=64'hFFFFFFFF_FFFFFFFD. DIV 7/-2: result_o=64'h00000001_FFFFFFFD.
- Divide by zero (DIV 5/0): ready_o after E1, result_o=0. DIVU 0xFFFFFFFF/1: result_o=64'h00000000_FFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF: result_o=64'h00000000_80000000 after 33 cycles.
- annul_i pulsed at cycle 10 of ON: state returns to FREE, ready_o never asserts. A new DIVU 9/3 issued next cycle -> result_o=64'h00000000_00000003.
- Rst_n asserted at cycle 20 of ON: next edge ready_o=0, result_o=0. A restart of DIVU 100/7 after reset completes with correct values.
